// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU codes,
// FSM states, datapath mux selects, decoded instruction class and control bundle.
package mc_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_MFHI   = 6'h10;
  localparam logic [5:0] F_MFLO   = 6'h12;
  localparam logic [5:0] F_MULT   = 6'h18;
  localparam logic [5:0] F_DIV    = 6'h1A;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUBU   = 6'h23;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_LUI = 4'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDU    = 3'd5
  } state_t;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;

  localparam logic [1:0] SRC_RT   = 2'd0;
  localparam logic [1:0] SRC_IMM  = 2'd1;
  localparam logic [1:0] SRC_FOUR = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_DM   = 2'd1;
  localparam logic [1:0] M2R_PC4  = 2'd2;
  localparam logic [1:0] M2R_HILO = 2'd3;

  // Exactly one bit set per decoded instruction; nop also covers unknown encodings.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic mult;
    logic div;
    logic mfhi;
    logic mflo;
    logic nop;
  } cls_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       pc_jump;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] alu_src;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [3:0] alu;
    logic       mdu_start;
    logic       busy;
  } ctrl_t;

  // Decoded instructions that write a register selected by the rd field.
  function automatic logic writes_rd(input cls_t c);
    return c.addu | c.subu | c.mfhi | c.mflo;
  endfunction

endpackage

// File: rtl/mc_controller_decode.sv
// Combinational op/func decode into a one-hot instruction class.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    unique case (op)
      OP_RTYPE: begin
        unique case (func)
          F_ADDU:  cls.addu = 1'b1;
          F_SUBU:  cls.subu = 1'b1;
          F_JR:    cls.jr   = 1'b1;
          F_MULT:  cls.mult = 1'b1;
          F_DIV:   cls.div  = 1'b1;
          F_MFHI:  cls.mfhi = 1'b1;
          F_MFLO:  cls.mflo = 1'b1;
          default: cls.nop  = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a shared 4-bit wait counter for mult/div latency and memory stalls.
module mc_controller
  import mc_defs::*;
#(
  parameter int ALU_W       = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int MEM_WAIT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  output logic             PCWrite,
  output logic             branch,
  output logic             PCJump,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       ALUSrc,
  output logic             MemWrite,
  output logic [1:0]       MemtoReg,
  output logic [ALU_W-1:0] ALU,
  output logic             mdu_start,
  output logic             busy,
  output logic [2:0]       state
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES - 1);
  localparam logic [3:0] MEM_LD  = 4'(MEM_WAIT);

  state_t     state_q;
  logic [3:0] cnt_q;
  cls_t       cls;
  ctrl_t      c;

  // The branch decision itself is taken in the datapath (branch & zero).
  logic unused_zero;
  assign unused_zero = zero;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .cls  (cls)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: state_q <= (cls.j | cls.jal | cls.nop) ? S_FETCH : S_EXEC;
        S_EXEC: begin
          if (cls.lw | cls.sw) begin
            state_q <= S_MEM;
            cnt_q   <= MEM_LD;
          end else if (cls.mult) begin
            state_q <= S_MDU;
            cnt_q   <= MULT_LD;
          end else if (cls.div) begin
            state_q <= S_MDU;
            cnt_q   <= DIV_LD;
          end else if (cls.beq | cls.jr) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - 4'd1;
          else             state_q <= cls.lw ? S_WB : S_FETCH;
        end
        S_MDU: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - 4'd1;
          else             state_q <= S_FETCH;
        end
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs depend only on registered state, counter and the stable IR fields.
  always_comb begin
    c = '0;
    unique case (state_q)
      S_FETCH: begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        c.alu_src  = SRC_FOUR;
        c.alu      = ALU_ADD;
      end
      S_DECODE: begin
        if (cls.j | cls.jal) begin
          c.pc_write = 1'b1;
          c.pc_jump  = 1'b1;
        end
        if (cls.jal) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = DST_RA;
          c.mem_to_reg = M2R_PC4;
        end
      end
      S_EXEC: begin
        if (cls.subu) c.alu = ALU_SUB;
        if (cls.ori) begin
          c.alu     = ALU_OR;
          c.alu_src = SRC_IMM;
        end
        if (cls.lui) begin
          c.alu     = ALU_LUI;
          c.alu_src = SRC_IMM;
        end
        if (cls.lw | cls.sw) begin
          c.alu     = ALU_ADD;
          c.alu_src = SRC_IMM;
        end
        if (cls.beq) begin
          c.alu    = ALU_SUB;
          c.branch = 1'b1;
        end
        if (cls.jr) begin
          c.pc_write = 1'b1;
          c.pc_jump  = 1'b1;
        end
        if (cls.mult | cls.div) c.mdu_start = 1'b1;
      end
      S_MEM: begin
        c.busy      = (cnt_q != '0);
        c.mem_write = cls.sw & (cnt_q == '0);
      end
      S_MDU: c.busy = 1'b1;
      S_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = writes_rd(cls) ? DST_RD : DST_RT;
        c.mem_to_reg = cls.lw ? M2R_DM : ((cls.mfhi | cls.mflo) ? M2R_HILO : M2R_ALU);
      end
      default: c = '0;
    endcase
    if (!reset) c = '0;
  end

  assign PCWrite   = c.pc_write;
  assign branch    = c.branch;
  assign PCJump    = c.pc_jump;
  assign IRWrite   = c.ir_write;
  assign RegWrite  = c.reg_write;
  assign RegDst    = c.reg_dst;
  assign ALUSrc    = c.alu_src;
  assign MemWrite  = c.mem_write;
  assign MemtoReg  = c.mem_to_reg;
  assign ALU       = ALU_W'(c.alu);
  assign mdu_start = c.mdu_start;
  assign busy      = c.busy;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a per-instruction cycle-sequence model
// feeds a queue that a negedge monitor compares against the DUT every cycle.
module tb_mc_controller;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int MEM_WAIT    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       zero;
  logic       PCWrite, branch, PCJump, IRWrite, RegWrite, MemWrite, mdu_start, busy;
  logic [1:0] RegDst, ALUSrc, MemtoReg;
  logic [3:0] ALU;
  logic [2:0] state;

  always #5 clk = ~clk;

  mc_controller #(
    .ALU_W(4), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .MEM_WAIT(MEM_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
    .PCWrite(PCWrite), .branch(branch), .PCJump(PCJump), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALU(ALU), .mdu_start(mdu_start), .busy(busy), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic pcw, br, pcj, irw, rw;
    logic [1:0] rdst, asrc;
    logic mw;
    logic [1:0] m2r;
    logic [3:0] alu;
    logic ms, bsy;
  } exp_t;

  typedef enum {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR,
                K_MULT, K_DIV, K_MFHI, K_MFLO, K_NOP} kind_t;

  exp_t exp_q[$];
  exp_t seq_q[$];
  exp_t act, e_mon;
  int   checks = 0, errors = 0;
  bit   mon_en = 0;

  assign act = {state, PCWrite, branch, PCJump, IRWrite, RegWrite, RegDst, ALUSrc,
                MemWrite, MemtoReg, ALU, mdu_start, busy};

  function automatic kind_t kind_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      case (f)
        6'h21: return K_ADDU;
        6'h23: return K_SUBU;
        6'h08: return K_JR;
        6'h18: return K_MULT;
        6'h1A: return K_DIV;
        6'h10: return K_MFHI;
        6'h12: return K_MFLO;
        default: return K_NOP;
      endcase
    end
    case (o)
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  // Expected per-cycle outputs of one instruction, written from the state-by-state rules.
  function automatic void build(input logic [5:0] o, input logic [5:0] f);
    kind_t k = kind_of(o, f);
    exp_t  r;
    int    n;
    seq_q.delete();
    r = '0; r.st = 3'd0; r.irw = 1; r.pcw = 1; r.asrc = 2'd2; seq_q.push_back(r);
    r = '0; r.st = 3'd1;
    if (k == K_J || k == K_JAL) begin r.pcw = 1; r.pcj = 1; end
    if (k == K_JAL) begin r.rw = 1; r.rdst = 2'd2; r.m2r = 2'd2; end
    seq_q.push_back(r);
    if (k == K_J || k == K_JAL || k == K_NOP) return;
    r = '0; r.st = 3'd2;
    case (k)
      K_SUBU:       r.alu = 4'd1;
      K_ORI:        begin r.alu = 4'd2; r.asrc = 2'd1; end
      K_LUI:        begin r.alu = 4'd3; r.asrc = 2'd1; end
      K_LW, K_SW:   r.asrc = 2'd1;
      K_BEQ:        begin r.alu = 4'd1; r.br = 1; end
      K_JR:         begin r.pcw = 1; r.pcj = 1; end
      K_MULT, K_DIV: r.ms = 1;
      default: ;
    endcase
    seq_q.push_back(r);
    if (k == K_BEQ || k == K_JR) return;
    if (k == K_MULT || k == K_DIV) begin
      n = (k == K_MULT) ? MULT_CYCLES : DIV_CYCLES;
      for (int i = 0; i < n; i++) begin r = '0; r.st = 3'd5; r.bsy = 1; seq_q.push_back(r); end
      return;
    end
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= MEM_WAIT; i++) begin
        r = '0; r.st = 3'd3; r.bsy = (i < MEM_WAIT); r.mw = (k == K_SW) && (i == MEM_WAIT);
        seq_q.push_back(r);
      end
      if (k == K_SW) return;
    end
    r = '0; r.st = 3'd4; r.rw = 1;
    r.rdst = (k == K_ADDU || k == K_SUBU || k == K_MFHI || k == K_MFLO) ? 2'd1 : 2'd0;
    r.m2r  = (k == K_LW) ? 2'd1 : ((k == K_MFHI || k == K_MFLO) ? 2'd3 : 2'd0);
    seq_q.push_back(r);
  endfunction

  // Issue one instruction; rst_at >= 0 pulls reset low during that cycle of it.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int rst_at);
    exp_t r;
    build(o, f);
    op = o; func = f;
    for (int i = 0; i < seq_q.size(); i++) begin
      zero = 1'($urandom);
      if (i == rst_at) begin
        r = '0; r.st = seq_q[i].st;
        exp_q.push_back(r);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      exp_q.push_back(seq_q[i]);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow t=%0t got st=%0d bits=%h, expected a queued entry", $time, act.st, act);
      end else begin
        e_mon = exp_q.pop_front();
        if (act !== e_mon) begin
          errors++;
          $display("FAIL cycle_out t=%0t op=%h func=%h got st=%0d bits=%h expected st=%0d bits=%h",
                   $time, op, func, act.st, act, e_mon.st, e_mon);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [5:0] tbl_op  [16] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02,
                               6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F};
  logic [5:0] tbl_fn  [16] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h08, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h00, 6'h00};

  initial begin
    int idx, ra;
    logic [5:0] o, f;
    reset = 1'b0; op = '0; func = '0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    exp_q.push_back('0);
    @(posedge clk); #1;
    exp_q.push_back('0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(6'h00, 6'h21, -1);  // addu
    run_instr(6'h23, 6'h00, -1);  // lw
    run_instr(6'h2B, 6'h00, -1);  // sw
    run_instr(6'h04, 6'h00, -1);  // beq (zero random per cycle)
    run_instr(6'h04, 6'h00, -1);
    run_instr(6'h00, 6'h18, -1);  // mult
    run_instr(6'h00, 6'h1A, -1);  // div
    run_instr(6'h03, 6'h00, -1);  // jal
    run_instr(6'h3F, 6'h2A, -1);  // unknown -> nop
    run_instr(6'h00, 6'h18, 5);   // reset in MDU_WAIT
    run_instr(6'h2B, 6'h00, 4);   // reset in MEM of sw before the write cycle
    run_instr(6'h2B, 6'h00, 5);   // reset in the final MEM cycle of sw
    run_instr(6'h0F, 6'h00, -1);

    for (int n = 0; n < 250; n++) begin
      idx = $urandom_range(0, 15);
      o = tbl_op[idx]; f = tbl_fn[idx];
      if (o != 6'h00) f = 6'($urandom);
      if ($urandom_range(0, 7) == 0) begin o = 6'($urandom); f = 6'($urandom); end
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(o, f, ra);
    end

    mon_en = 0;
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain leftover=%0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
